// File: rtl/alib_points_stream_fifo.sv
// First-word-fall-through FIFO for packed multi-channel points.
// Tracks stored point count and complete frames (in_last markers).
module alib_points_stream_fifo #(
  parameter int DEPTH    = 16,
  parameter int COORD_W  = 16,
  parameter int NUM_CH   = 3,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*COORD_W-1:0]     in_point,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*COORD_W-1:0]     out_point,
  output logic                          out_last,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          almost_full,
  output logic [$clog2(DEPTH+1)-1:0]    frame_count
);

  localparam int DW = NUM_CH * COORD_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(AFULL_TH);

  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW:0]   head;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PTR_MAX) ptr_inc = '0;
    else              ptr_inc = p + 1'b1;
  endfunction

  // Handshake qualification and head presentation
  always_comb begin
    in_ready    = rst && (count < CNT_MAX);
    out_valid   = (count != '0);
    head        = mem[rd_ptr];
    out_point   = out_valid ? head[DW-1:0] : '0;
    out_last    = out_valid & head[DW];
    almost_full = (count >= AF_TH);
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    push_last   = push && in_last;
    pop_last    = pop && out_last;
  end

  // Point storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_last, in_point};
    end
  end

  // Pointers with explicit wrap at DEPTH-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Occupancy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // Complete-frame counter driven by last markers in and out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count <= '0;
    end else if (flush) begin
      frame_count <= '0;
    end else if (push_last && !pop_last) begin
      frame_count <= frame_count + 1'b1;
    end else if (pop_last && !push_last) begin
      frame_count <= frame_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_alib_points_stream_fifo.sv
// Directed bench for alib_points_stream_fifo at DEPTH=4.
// Linear stimulus with immediate-assertion checks.
module tb_alib_points_stream_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int NC    = 3;
  localparam int AF    = 3;
  localparam int DW    = NC * CW;
  localparam int KW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_point;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_point;
  logic          out_last;
  logic [KW-1:0] count;
  logic          almost_full;
  logic [KW-1:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q [0:10];

  alib_points_stream_fifo #(
    .DEPTH(DEPTH), .COORD_W(CW),
    .NUM_CH(NC), .AFULL_TH(AF)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_point(in_point), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_point(out_point), .out_last(out_last),
    .count(count), .almost_full(almost_full),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic v, input logic [DW-1:0] p,
    input logic l, input logic r
  );
    in_valid  = v;
    in_point  = p;
    in_last   = l;
    out_ready = r;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i <= 10; i++)
      q[i] = DW'(48'h0100_0200_0300 + 48'(i) * 48'h0001_0001_0001);

    // reset state
    #12;
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_count", DW'(count), '0);
    chk("rst_afull", DW'(almost_full), '0);
    chk("rst_point", out_point, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", DW'(in_ready), DW'(1));

    // two pushes, head visible one cycle after first
    @(posedge clk); #1;
    drive(1'b1, 48'h0001_0002_0003, 1'b0, 1'b0);
    chk("pre_push_valid", DW'(out_valid), '0);
    tick();
    chk("p1_valid", DW'(out_valid), DW'(1));
    chk("p1_point", out_point, 48'h0001_0002_0003);
    drive(1'b1, 48'h0004_0005_0006, 1'b0, 1'b0);
    tick();
    chk("p2_count", DW'(count), DW'(2));
    chk("p2_head", out_point, 48'h0001_0002_0003);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("d1_head", out_point, 48'h0004_0005_0006);
    tick();
    chk("d2_count", DW'(count), '0);
    chk("d2_point", out_point, '0);
    chk("d2_last", DW'(out_last), '0);

    // fill to full, fifth stalls until a pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, q[i], 1'b0, 1'b0);
      tick();
      chk("fill_count", DW'(count), DW'(i + 1));
      chk("fill_afull", DW'(almost_full), DW'(i >= 2));
    end
    chk("full_in_ready", DW'(in_ready), '0);
    drive(1'b1, q[4], 1'b0, 1'b0);
    tick();
    chk("stall_count", DW'(count), DW'(4));
    drive(1'b1, q[4], 1'b0, 1'b1);
    chk("full_pop_head", out_point, q[0]);
    tick();
    chk("full_pop_count", DW'(count), DW'(3));
    chk("full_pop_ready", DW'(in_ready), DW'(1));
    drive(1'b1, q[4], 1'b0, 1'b0);
    tick();
    chk("p5_count", DW'(count), DW'(4));
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_point, q[i]);
      tick();
    end
    chk("drain_empty", DW'(out_valid), '0);

    // steady push+pop at count 3 across wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, q[i], 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, q[i + 3], 1'b0, 1'b1);
      chk("stream_head", out_point, q[i]);
      tick();
      chk("stream_count", DW'(count), DW'(3));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 8; i <= 10; i++) begin
      chk("stream_tail", out_point, q[i]);
      tick();
    end
    chk("stream_empty", DW'(count), '0);

    // frame markers
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, q[i], (i % 2) == 1, 1'b0);
      tick();
    end
    chk("frm_2", DW'(frame_count), DW'(2));
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("frm_pop1", DW'(frame_count), DW'(2));
    chk("frm_head_last", DW'(out_last), DW'(1));
    tick();
    chk("frm_pop2", DW'(frame_count), DW'(1));
    tick();
    chk("frm_pop3", DW'(frame_count), DW'(1));
    chk("frm_last_head", DW'(out_last), DW'(1));
    drive(1'b1, q[5], 1'b1, 1'b1);
    tick();
    chk("frm_both", DW'(frame_count), DW'(1));
    chk("frm_both_cnt", DW'(count), DW'(1));
    chk("frm_new_head", out_point, q[5]);

    // flush overrides handshakes
    drive(1'b1, q[6], 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_flush_cnt", DW'(count), DW'(3));
    flush = 1'b1;
    drive(1'b1, q[7], 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", DW'(count), '0);
    chk("flush_frames", DW'(frame_count), '0);
    chk("flush_valid", DW'(out_valid), '0);
    tick();
    chk("flush_lost", DW'(out_valid), '0);

    // async reset mid-burst
    drive(1'b1, q[8], 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", DW'(out_valid), '0);
    chk("arst_count", DW'(count), '0);
    chk("arst_ready", DW'(in_ready), '0);
    chk("arst_point", out_point, '0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arel_ready", DW'(in_ready), DW'(1));
    drive(1'b1, 48'h00AA_00BB_00CC, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arel_head", out_point, 48'h00AA_00BB_00CC);
    chk("arel_count", DW'(count), DW'(1));
    chk("arel_last", DW'(out_last), '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alib_points_stream_fifo.md
ALIB_POINTS_STREAM_FIFO -- requirements
Module: alib_points_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; any integer >= 2, not restricted to powers of two.
REQ-002 SHALL have parameter COORD_W, default 16, bits per channel.
REQ-003 SHALL have parameter NUM_CH, default 3, channels per point (x,y,z,intensity,...); channel 0 in MSBs.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full threshold; legal range 1..DEPTH.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port in_valid  input  1  producer offers a point.
REQ-009 SHALL have port in_ready  output  1  FIFO can accept.
REQ-010 SHALL have port in_point  input  NUM_CH*COORD_W  packed point.
REQ-011 SHALL have port in_last  input  1  last point of a frame.
REQ-012 SHALL have port out_valid  output  1  head point present.
REQ-013 SHALL have port out_ready  input  1  consumer takes head.
REQ-014 SHALL have port out_point  output  NUM_CH*COORD_W  head point.
REQ-015 SHALL have port out_last  output  1  frame marker of head.
REQ-016 SHALL have port count  output  clog2(DEPTH+1)  stored points.
REQ-017 SHALL have port almost_full  output  1  count >= AFULL_TH.
REQ-018 SHALL have port frame_count  output  clog2(DEPTH+1)  complete frames stored (in_last markers held).

Function
REQ-019 Push SHALL occur iff in_valid && in_ready; pop iff out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH) while rst high; 0 while rst low.
REQ-021 out_valid SHALL equal (count != 0); first-word-fall-through: out_point/out_last show the head entry combinationally from storage.
REQ-022 out_point and out_last SHALL be 0 whenever out_valid is 0.
REQ-023 A point pushed in cycle N SHALL be visible at the output (if FIFO was empty) in cycle N+1; no earlier.
REQ-024 Write and read pointers SHALL wrap from DEPTH-1 to 0 explicitly.
REQ-025 count SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 Simultaneous push and pop SHALL be legal at any occupancy where both are enabled, including count=DEPTH-1 and count=1; data order preserved.
REQ-027 When full, in_ready=0 so no push occurs even if out_ready pops that cycle (no same-cycle refill at full).
REQ-028 frame_count SHALL be +1 on push with in_last=1, -1 on pop with out_last=1, unchanged when both occur.
REQ-029 flush=1 SHALL, at the next edge, zero pointers, count and frame_count; any push/pop handshake in that cycle is discarded; flush overrides all.
REQ-030 Storage contents SHALL need no reset; only pointers, count, frame_count are reset.
REQ-031 No overflow/underflow state SHALL be reachable; in_valid while full simply stalls.

Reset
REQ-032 rst low SHALL immediately (asynchronously) clear pointers, count=0, frame_count=0, giving out_valid=0, out_point=0, out_last=0, almost_full=0, in_ready=0.
REQ-033 Assertion mid-transfer SHALL drop all stored points; after rst rises, first edge behaves as empty FIFO with in_ready=1.

Verification (DEPTH=4, COORD_W=16, NUM_CH=3, AFULL_TH=3)
REQ-034 Push 0x0001_0002_0003, 0x0004_0005_0006 with out_ready=0 -> count=2, out_point=0x000100020003, out_valid=1 one cycle after first push.
REQ-035 Push 5 points continuously, out_ready=0 -> in_ready=0 after 4th, count=4, almost_full=1 from count=3, 5th point held until a pop, then accepted next cycle.
REQ-036 Fill 3, then push+pop simultaneously for 8 cycles across pointer wrap -> count stays 3, output sequence equals input order exactly.
REQ-037 Push points with in_last on 2nd and 4th, pop 2 -> frame_count 2 then 1; push-with-last concurrent with pop-with-last keeps it at 1.
REQ-038 With count=3, assert flush with in_valid=out_ready=1 -> next cycle count=0, frame_count=0, out_valid=0, pushed point lost.
REQ-039 Drop rst mid-burst between clock edges -> outputs clear before next edge; after release, push of 0x00AA_00BB_00CC appears alone at head.
